// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - PWM period/duty runtime config with boundary-aligned apply and duty ramp
// Optional mid-ramp retargeting is compiled in with `define PWM_RAMP_RETARGET_EN.
module pwm_ramp_ctrl #(
  parameter int PW         = 16,
  parameter int STEP       = 1,
  parameter int RAMP_DIV   = 1,
  parameter int PERIOD_RST = 100,
  parameter int DUTY_RST   = 0
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          EN,
  input  logic          CFG_VALID,
  output logic          CFG_READY,
  input  logic [PW-1:0] CFG_PERIOD,
  input  logic [PW-1:0] CFG_DUTY,
  input  logic          WRAP,
  output logic [PW-1:0] PERIOD_OUT,
  output logic [PW-1:0] DUTY_OUT,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PEND = 2'd1;
  localparam logic [1:0] RAMP = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam int            DIVW     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(RAMP_DIV - 1);
  localparam logic [PW:0]   STEP_W   = (PW+1)'(STEP);

  logic [1:0]      state, state_nxt;
  logic [PW-1:0]   sh_per, sh_per_nxt, sh_tgt, sh_tgt_nxt;
  logic [PW-1:0]   period_nxt, duty_nxt;
  logic [DIVW-1:0] divider, div_nxt;
  logic            done_nxt, err_nxt, busy_nxt;
  logic            accept, cfg_ok;
  logic [PW:0]     dext, text, diff, stepped;

`ifdef PWM_RAMP_RETARGET_EN
  assign CFG_READY = EN;
`else
  assign CFG_READY = EN && (state == IDLE || state == HOLD);
`endif

  assign accept = CFG_VALID && CFG_READY;
  assign cfg_ok = accept && (CFG_PERIOD != '0);

  // One clamped step toward target, done one bit wider so the step cannot wrap
  always_comb begin
    dext    = {1'b0, DUTY_OUT};
    text    = {1'b0, sh_tgt};
    diff    = '0;
    stepped = text;
    if (dext < text) begin
      diff    = text - dext;
      stepped = (diff <= STEP_W) ? text : dext + STEP_W;
    end else begin
      diff    = dext - text;
      stepped = (diff <= STEP_W) ? text : dext - STEP_W;
    end
  end

  always_comb begin
    state_nxt  = state;
    period_nxt = PERIOD_OUT;
    duty_nxt   = DUTY_OUT;
    sh_per_nxt = sh_per;
    sh_tgt_nxt = sh_tgt;
    div_nxt    = divider;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;

    if (accept) begin
      if (CFG_PERIOD == '0) begin
        err_nxt = 1'b1;
      end else begin
        sh_per_nxt = CFG_PERIOD;
        sh_tgt_nxt = (CFG_DUTY > CFG_PERIOD) ? CFG_PERIOD : CFG_DUTY;
        err_nxt    = (CFG_DUTY > CFG_PERIOD);
        state_nxt  = PEND;
      end
    end

    // A wrap coinciding with a fresh accept waits for the next boundary
    if (EN && WRAP && !cfg_ok) begin
      case (state)
        PEND: begin
          period_nxt = sh_per;
          duty_nxt   = (DUTY_OUT > sh_per) ? sh_per : DUTY_OUT;
          div_nxt    = '0;
          if (duty_nxt == sh_tgt) begin
            done_nxt  = 1'b1;
            state_nxt = HOLD;
          end else begin
            state_nxt = RAMP;
          end
        end
        RAMP: begin
          if (divider == DIV_LAST) begin
            div_nxt  = '0;
            duty_nxt = stepped[PW-1:0];
            if (stepped[PW-1:0] == sh_tgt) begin
              done_nxt  = 1'b1;
              state_nxt = HOLD;
            end
          end else begin
            div_nxt = divider + 1'b1;
          end
        end
        default: ;
      endcase
    end

    busy_nxt = (state_nxt == PEND) || (state_nxt == RAMP);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      PERIOD_OUT <= PW'(PERIOD_RST);
      DUTY_OUT   <= PW'(DUTY_RST);
      sh_per     <= PW'(PERIOD_RST);
      sh_tgt     <= PW'(DUTY_RST);
      divider    <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      state      <= state_nxt;
      PERIOD_OUT <= period_nxt;
      DUTY_OUT   <= duty_nxt;
      sh_per     <= sh_per_nxt;
      sh_tgt     <= sh_tgt_nxt;
      divider    <= div_nxt;
      BUSY       <= busy_nxt;
      DONE       <= done_nxt;
      ERR        <= err_nxt;
    end
  end

endmodule
